// File: rtl/uart_tx_ticked.sv
// UART transmitter driven by a 16x oversample tick: start bit, DBIT data bits (LSB first),
// then a stop bit of SB_TICK ticks.
module uart_tx_ticked #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [4:0] LastBitTick  = 5'd15;
    localparam logic [4:0] LastStopTick = 5'(SB_TICK - 1);
    localparam logic [2:0] LastDataBit  = 3'(DBIT - 1);

    state_e     state_q;
    logic [4:0] s_cnt_q;
    logic [2:0] n_cnt_q;
    logic [7:0] b_q;
    logic       tx_q;
    logic       done_q;

    // tx_q is updated on the same edge as state_q so the line always matches the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            s_cnt_q <= 5'd0;
            n_cnt_q <= 3'd0;
            b_q     <= 8'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tx_start) begin
                        b_q     <= din;
                        s_cnt_q <= 5'd0;
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (s_tick) begin
                        if (s_cnt_q == LastBitTick) begin
                            s_cnt_q <= 5'd0;
                            n_cnt_q <= 3'd0;
                            state_q <= StData;
                            tx_q    <= b_q[0];
                        end else begin
                            s_cnt_q <= s_cnt_q + 5'd1;
                        end
                    end
                end
                StData: begin
                    if (s_tick) begin
                        if (s_cnt_q == LastBitTick) begin
                            s_cnt_q <= 5'd0;
                            b_q     <= b_q >> 1;
                            if (n_cnt_q == LastDataBit) begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end else begin
                                n_cnt_q <= n_cnt_q + 3'd1;
                                tx_q    <= b_q[1];
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 5'd1;
                        end
                    end
                end
                StStop: begin
                    if (s_tick) begin
                        if (s_cnt_q == LastStopTick) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            s_cnt_q <= s_cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_busy      = (state_q != StIdle);
    assign tx_done_tick = done_q;
    assign tx           = tx_q;

endmodule

// File: doc/uart_tx_ticked.md
Name: uart_tx_ticked

Overview:
- Serial UART transmitter; the consumer end of the baud-tick generator.
- Takes the 16x-oversample enable pulse `s_tick` from the team's mod-M tick counter.
- Serialises a parallel byte into start, data and stop bits on the line `tx`.
- Sits between the game-logic/debug message path and the board UART pin, mirroring the existing receive path.

Parameters:
- DBIT, default 8: data bits per frame. Legal range 1..8.
- SB_TICK, default 16: s_tick count for the stop bit. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2. Legal range 1..32.

Ports:
- clk, input, 1: system clock. All state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset. 0 resets the block.
- s_tick, input, 1: oversample enable, one clk cycle wide, 16 per bit period.
- tx_start, input, 1: request to send `din`. Sampled only in IDLE.
- din, input, 8: data byte. Bits [DBIT-1:0] are sent LSB first.
- tx_busy, output, 1: 1 whenever state is not IDLE.
- tx_done_tick, output, 1: one-cycle pulse at frame end.
- tx, output, 1: serial line. Idles high.

Behaviour:
- Registers:
  - state: IDLE, START, DATA, STOP.
  - s_cnt: 5-bit tick counter.
  - n_cnt: 3-bit bit counter.
  - b_reg: 8-bit shift register.
  - tx_reg: line driver.
  - tx_done_tick: registered pulse.
- Reset (reset=0, asynchronous): state=IDLE, s_cnt=0, n_cnt=0, b_reg=0, tx=1, tx_done_tick=0, tx_busy=0. Applies immediately, including mid-frame. No done pulse is produced for an aborted frame.
- tx_reg is loaded on the same edge that changes state, so `tx` always equals the current state's line level.
- IDLE:
  - tx=1.
  - If tx_start=1: at the edge, b_reg<=din, s_cnt<=0, state<=START, tx<=0.
  - s_tick ignored.
- START:
  - tx=0.
  - On each s_tick: if s_cnt==15, then s_cnt<=0, n_cnt<=0, state<=DATA, tx<=din bit 0 (b_reg[0]). Otherwise s_cnt<=s_cnt+1.
- DATA:
  - tx=b_reg[0].
  - On each s_tick: if s_cnt==15, then s_cnt<=0 and b_reg<=b_reg>>1.
    - If n_cnt==DBIT-1: state<=STOP, tx<=1.
    - Otherwise: n_cnt<=n_cnt+1, tx<=next bit.
  - If s_cnt!=15: s_cnt<=s_cnt+1.
- STOP:
  - tx=1.
  - On each s_tick: if s_cnt==SB_TICK-1, then state<=IDLE and tx_done_tick<=1 for exactly one clk. Otherwise s_cnt<=s_cnt+1.
- Cycles without s_tick hold all registers except tx_done_tick, which clears to 0.
- Timing:
  - Each start/data bit lasts exactly 16 s_ticks.
  - Stop bit lasts SB_TICK s_ticks.
  - Frame = (16*(1+DBIT)+SB_TICK) s_ticks.
- Latency: tx falls on the edge that samples tx_start. This is independent of s_tick phase, so the first start-bit tick interval may be partial.
- din is captured only on the accepting edge. Later din changes do not affect the frame.
- tx_start while busy: ignored, not queued.
- tx_start in the same cycle tx_done_tick is being generated (state still STOP): ignored. The earliest accepted start is the next cycle, when in IDLE.
- tx_start held high continuously: back-to-back frames, one idle clk between frames.
- s_tick and tx_start in the same IDLE cycle: the tick is not counted.
- tx_busy is combinational from state (state!=IDLE), so it rises the cycle after acceptance.

Test Plan:
- Reset release, no stimulus, s_tick every 4 clks for 500 clks -> tx=1, tx_busy=0, tx_done_tick=0 throughout.
- din=8'hA5, one-cycle tx_start, s_tick every 4 clks, defaults:
  - tx sequence, each bit for 16 ticks (64 clks): 0,1,0,1,0,0,1,0,1,1.
  - tx_done_tick is a single pulse 160 ticks after start.
  - tx_busy=1 for the whole frame.
- din changed to 8'hFF one cycle after starting 8'h3C -> line carries 0x3C (bits 0,0,1,1,1,1,0,0 LSB first).
- Second tx_start during DATA of frame 8'h55 -> ignored; exactly one tx_done_tick; line idle after stop.
- tx_start held high, din=8'h01 -> two consecutive frames separated by exactly one idle clk; two tx_done_tick pulses.
- reset=0 asserted mid-DATA of 8'hF0 -> tx=1 immediately (asynchronous), no tx_done_tick. A new tx_start after reset release sends a full, correct frame.
- DBIT=7, SB_TICK=32, din=8'h80 -> 7 data bits all 0, stop bit lasts 32 ticks, done pulse at tick 160.
